// File: rtl/mips_hazard_pkg.sv
// Shared encodings for the MIPS pipeline hazard unit: forwarding-mux selects
// and the memory-wait FSM states.
package mips_hazard_pkg;

   // E-stage operand mux selects
   localparam logic [1:0] FWD_RF  = 2'b00;
   localparam logic [1:0] FWD_WB  = 2'b01;
   localparam logic [1:0] FWD_MEM = 2'b10;

   typedef enum logic {
      IDLE = 1'b0,
      WAIT = 1'b1
   } wait_state_t;

endpackage

// File: rtl/mem_wait_ctr.sv
// Data-memory wait-state FSM. Holds an access in M for LOAD_LAT cycles by
// raising mem_stall for the first LOAD_LAT-1 of them.
module mem_wait_ctr
   import mips_hazard_pkg::*;
#(
   parameter int LOAD_LAT = 1
) (
   input  logic clk,
   input  logic rst_n,
   input  logic mem_req,
   output logic mem_stall
);

   // Cycles still to wait after the first stalled one
   localparam logic [3:0] CNT_INIT = (LOAD_LAT > 1) ? 4'(LOAD_LAT - 2) : 4'd0;
   localparam bit         HAS_WAIT = (LOAD_LAT > 1);

   wait_state_t state, state_nxt;
   logic [3:0]  cnt, cnt_nxt;

   // State and down-counter registers; reset aborts any wait in progress
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
         cnt   <= 4'd0;
      end else begin
         state <= state_nxt;
         cnt   <= cnt_nxt;
      end
   end

   // Next-state and stall decode; requests arriving during WAIT are ignored
   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      mem_stall = 1'b0;
      case (state)
         IDLE: begin
            if (mem_req && HAS_WAIT) begin
               mem_stall = 1'b1;
               state_nxt = WAIT;
               cnt_nxt   = CNT_INIT;
            end
         end
         WAIT: begin
            if (cnt != 4'd0) begin
               mem_stall = 1'b1;
               cnt_nxt   = cnt - 4'd1;
            end else begin
               state_nxt = IDLE;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

endmodule

// File: rtl/hazard_unit.sv
// Pipeline hazard controller for the 5-stage MIPS core: M/W->E forwarding,
// load-use and branch stalls, memory wait states, stall-cycle counter.
// Build option: define BRANCH_FWD_EN to forward the M result into the D-stage
// branch comparator instead of waiting for the producer to reach W.
module hazard_unit
   import mips_hazard_pkg::*;
#(
   parameter int REG_AW      = 5,
   parameter int LOAD_LAT    = 1,
   parameter int STALL_CNT_W = 16
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic [REG_AW-1:0]      rs_d,
   input  logic [REG_AW-1:0]      rt_d,
   input  logic                   branch_d,
   input  logic                   pc_src_d,
   input  logic [REG_AW-1:0]      rs_e,
   input  logic [REG_AW-1:0]      rt_e,
   input  logic [REG_AW-1:0]      write_reg_e,
   input  logic                   reg_write_e,
   input  logic                   mem_to_reg_e,
   input  logic [REG_AW-1:0]      write_reg_m,
   input  logic                   reg_write_m,
   input  logic                   mem_to_reg_m,
   input  logic                   mem_req_m,
   input  logic [REG_AW-1:0]      write_reg_w,
   input  logic                   reg_write_w,
   output logic [1:0]             forward_ae,
   output logic [1:0]             forward_be,
   output logic                   forward_ad,
   output logic                   forward_bd,
   output logic                   stall_f,
   output logic                   stall_d,
   output logic                   stall_e,
   output logic                   stall_m,
   output logic                   flush_d,
   output logic                   flush_e,
   output logic                   flush_w,
   output logic [STALL_CNT_W-1:0] stall_cycles
);

   logic mem_stall;
   logic lu, br;
   logic hit_e, hit_m;

   mem_wait_ctr #(.LOAD_LAT(LOAD_LAT)) u_wait (
      .clk      (clk),
      .rst_n    (rst_n),
      .mem_req  (mem_req_m),
      .mem_stall(mem_stall)
   );

   // E operand forwarding; M is newer than W so it wins, $0 never forwards
   always_comb begin
      forward_ae = FWD_RF;
      forward_be = FWD_RF;
      if (rs_e != '0 && rs_e == write_reg_m && reg_write_m)      forward_ae = FWD_MEM;
      else if (rs_e != '0 && rs_e == write_reg_w && reg_write_w) forward_ae = FWD_WB;
      if (rt_e != '0 && rt_e == write_reg_m && reg_write_m)      forward_be = FWD_MEM;
      else if (rt_e != '0 && rt_e == write_reg_w && reg_write_w) forward_be = FWD_WB;
   end

   assign lu = mem_to_reg_e && write_reg_e != '0 &&
               (write_reg_e == rs_d || write_reg_e == rt_d);

   assign hit_e = write_reg_e != '0 && (write_reg_e == rs_d || write_reg_e == rt_d);
   assign hit_m = write_reg_m != '0 && (write_reg_m == rs_d || write_reg_m == rt_d);

`ifdef BRANCH_FWD_EN
   // ALU results in M are forwarded; only an E producer or an M load stalls
   assign forward_ad = rs_d != '0 && rs_d == write_reg_m && reg_write_m;
   assign forward_bd = rt_d != '0 && rt_d == write_reg_m && reg_write_m;
   assign br = branch_d && ((reg_write_e && hit_e) || (mem_to_reg_m && hit_m));
`else
   // No comparator bypass: wait until the producer is in W (RF writes first half)
   logic unused_mem_to_reg_m;
   assign unused_mem_to_reg_m = mem_to_reg_m;
   assign forward_ad = 1'b0;
   assign forward_bd = 1'b0;
   assign br = branch_d && ((reg_write_e && hit_e) || (reg_write_m && hit_m));
`endif

   // Stage enables/clears; a memory wait freezes E so a pending lu bubble
   // is only inserted once the wait ends. All forced low during reset.
   always_comb begin
      stall_f = rst_n & (lu | br | mem_stall);
      stall_d = stall_f;
      stall_e = rst_n & mem_stall;
      stall_m = stall_e;
      flush_e = rst_n & (lu | br) & ~mem_stall;
      flush_w = rst_n & mem_stall;
      flush_d = rst_n & pc_src_d & ~stall_d;
   end

   // Saturating count of fetch-stall cycles
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)                             stall_cycles <= '0;
      else if (stall_f && stall_cycles != '1) stall_cycles <= stall_cycles + 1'b1;
   end

endmodule

// File: tb/tb_hazard_unit.sv
// Self-checking bench for hazard_unit (LOAD_LAT=4, 4-bit stall counter so
// saturation is reachable). Directed steps followed by a random phase.
module tb_hazard_unit;

   localparam int LL = 4;
   localparam int CW = 4;
   localparam int CMAX = (1 << CW) - 1;

   logic clk, rst_n;
   logic [4:0] rs_d, rt_d, rs_e, rt_e, write_reg_e, write_reg_m, write_reg_w;
   logic branch_d, pc_src_d, reg_write_e, mem_to_reg_e;
   logic reg_write_m, mem_to_reg_m, mem_req_m, reg_write_w;
   logic [1:0] forward_ae, forward_be;
   logic forward_ad, forward_bd, stall_f, stall_d, stall_e, stall_m;
   logic flush_d, flush_e, flush_w;
   logic [CW-1:0] stall_cycles;

   hazard_unit #(.REG_AW(5), .LOAD_LAT(LL), .STALL_CNT_W(CW)) dut (
      .clk(clk), .rst_n(rst_n), .rs_d(rs_d), .rt_d(rt_d),
      .branch_d(branch_d), .pc_src_d(pc_src_d), .rs_e(rs_e), .rt_e(rt_e),
      .write_reg_e(write_reg_e), .reg_write_e(reg_write_e),
      .mem_to_reg_e(mem_to_reg_e), .write_reg_m(write_reg_m),
      .reg_write_m(reg_write_m), .mem_to_reg_m(mem_to_reg_m),
      .mem_req_m(mem_req_m), .write_reg_w(write_reg_w),
      .reg_write_w(reg_write_w), .forward_ae(forward_ae),
      .forward_be(forward_be), .forward_ad(forward_ad),
      .forward_bd(forward_bd), .stall_f(stall_f), .stall_d(stall_d),
      .stall_e(stall_e), .stall_m(stall_m), .flush_d(flush_d),
      .flush_e(flush_e), .flush_w(flush_w), .stall_cycles(stall_cycles)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   // Reference model state: age of the access in M (-1 = none) and counter
   int age  = -1;
   int mcnt = 0;
   int cur;
   bit e_sf, e_ms;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [1:0] ref_fwd(input logic [4:0] src);
      if (src != 0 && src == write_reg_m && reg_write_m) return 2'd2;
      if (src != 0 && src == write_reg_w && reg_write_w) return 2'd1;
      return 2'd0;
   endfunction

   function automatic bit uses(input logic [4:0] dst);
      return dst != 0 && (dst == rs_d || dst == rt_d);
   endfunction

   // Let inputs settle, then compare every output against the model
   task automatic settle();
      bit lu, br, ad, bd;
      #1;
      if (!rst_n) begin
         age = -1;
         mcnt = 0;
      end
      cur  = (age >= 0) ? age : ((mem_req_m && LL > 1) ? 0 : -1);
      e_ms = (cur >= 0) && (cur < LL - 1);
      lu   = mem_to_reg_e && uses(write_reg_e);
`ifdef BRANCH_FWD_EN
      ad = rs_d != 0 && rs_d == write_reg_m && reg_write_m;
      bd = rt_d != 0 && rt_d == write_reg_m && reg_write_m;
      br = branch_d && ((reg_write_e && uses(write_reg_e)) || (mem_to_reg_m && uses(write_reg_m)));
`else
      ad = 0;
      bd = 0;
      br = branch_d && ((reg_write_e && uses(write_reg_e)) || (reg_write_m && uses(write_reg_m)));
`endif
      e_sf = rst_n && (lu || br || e_ms);
      chk("forward_ae", forward_ae, ref_fwd(rs_e));
      chk("forward_be", forward_be, ref_fwd(rt_e));
      chk("forward_ad", forward_ad, ad);
      chk("forward_bd", forward_bd, bd);
      chk("stall_f", stall_f, e_sf);
      chk("stall_d", stall_d, e_sf);
      chk("stall_e", stall_e, rst_n && e_ms);
      chk("stall_m", stall_m, rst_n && e_ms);
      chk("flush_e", flush_e, rst_n && (lu || br) && !e_ms);
      chk("flush_w", flush_w, rst_n && e_ms);
      chk("flush_d", flush_d, rst_n && pc_src_d && !e_sf);
      chk("stall_cycles", stall_cycles, mcnt);
   endtask

   // Advance model across the rising edge and return to the falling edge
   task automatic tick();
      if (rst_n) begin
         if (e_sf && mcnt < CMAX) mcnt++;
         age = e_ms ? cur + 1 : -1;
      end
      @(negedge clk);
   endtask

   task automatic clr();
      {rs_d, rt_d, rs_e, rt_e, write_reg_e, write_reg_m, write_reg_w} = '0;
      {branch_d, pc_src_d, reg_write_e, mem_to_reg_e} = '0;
      {reg_write_m, mem_to_reg_m, mem_req_m, reg_write_w} = '0;
   endtask

   initial begin
      rst_n = 1'b0;
      clr();
      @(negedge clk);
      // reset state
      settle();
      chk("rst_cnt", stall_cycles, 0);
      tick();
      rst_n = 1'b1;

      // forwarding priority and $0 exclusion
      rs_e = 3; rt_e = 3; write_reg_m = 3; reg_write_m = 1; write_reg_w = 3; reg_write_w = 1;
      settle(); chk("t1_ae_m", forward_ae, 2'b10); chk("t1_be_m", forward_be, 2'b10); tick();
      reg_write_m = 0;
      settle(); chk("t1_ae_w", forward_ae, 2'b01); tick();
      rs_e = 0;
      settle(); chk("t1_ae_rf", forward_ae, 2'b00); chk("t1_be_w", forward_be, 2'b01); tick();

      // load-use: one bubble
      clr();
      mem_to_reg_e = 1; reg_write_e = 1; write_reg_e = 8; rt_d = 8;
      settle(); chk("t2_stall_f", stall_f, 1); chk("t2_flush_e", flush_e, 1); tick();
      clr();
      settle(); chk("t2_clear", stall_f, 0); chk("t2_cnt", stall_cycles, 1); tick();
      // load to $0 is never a hazard
      mem_to_reg_e = 1; write_reg_e = 0; rs_d = 0;
      settle(); chk("t2_zero", stall_f, 0); tick();

      // memory wait: 3 stalled cycles, M moves on the 4th
      clr();
      mem_req_m = 1;
      for (int i = 0; i < LL - 1; i++) begin
         settle(); chk("t3_stall_m", stall_m, 1); chk("t3_flush_w", flush_w, 1); tick();
      end
      settle(); chk("t3_release", stall_m, 0); tick();
      mem_req_m = 0;
      settle(); chk("t3_idle", stall_m, 0); chk("t3_cnt", stall_cycles, 4); tick();

      // load-use coinciding with a memory wait: bubble after the wait
      mem_to_reg_e = 1; write_reg_e = 9; rs_d = 9; mem_req_m = 1;
      for (int i = 0; i < LL - 1; i++) begin
         settle(); chk("t4_no_flush", flush_e, 0); tick();
      end
      settle(); chk("t4_flush", flush_e, 1); chk("t4_stall", stall_f, 1); tick();
      clr();
      settle(); tick();

      // branch on an M-stage ALU result
      branch_d = 1; rs_d = 5; write_reg_m = 5; reg_write_m = 1;
      settle();
`ifdef BRANCH_FWD_EN
      chk("t5_fwd", forward_ad, 1); chk("t5_nostall", stall_f, 0);
`else
      chk("t5_fwd", forward_ad, 0); chk("t5_stall", stall_f, 1);
`endif
      tick();
      pc_src_d = 1;
      settle();
`ifdef BRANCH_FWD_EN
      chk("t5_flush_d", flush_d, 1);
`else
      chk("t5_flush_d", flush_d, 0);
`endif
      tick();
      clr();
      // taken branch without hazard flushes IF-ID
      pc_src_d = 1; branch_d = 1;
      settle(); chk("t5_flush_d2", flush_d, 1); tick();

      // reset in the middle of a wait
      clr();
      mem_req_m = 1;
      settle(); tick();
      settle(); tick();
      settle(); chk("t6_pre", stall_m, 1);
      #2 rst_n = 1'b0;
      settle(); chk("t6_stall_m", stall_m, 0); chk("t6_stall_f", stall_f, 0);
      chk("t6_cnt", stall_cycles, 0);
      tick();
      rst_n = 1'b1; mem_req_m = 0;
      settle(); chk("t6_idle", stall_m, 0); chk("t6_cnt_after", stall_cycles, 0); tick();
      mem_req_m = 1;
      settle(); chk("t6_new_wait", stall_m, 1); tick();
      mem_req_m = 0;
      for (int i = 0; i < LL; i++) begin settle(); tick(); end

      // random traffic against the model
      for (int n = 0; n < 400; n++) begin
         rst_n        = ($urandom_range(0, 59) != 0);
         rs_d         = 5'($urandom_range(0, 3));
         rt_d         = 5'($urandom_range(0, 3));
         rs_e         = 5'($urandom_range(0, 3));
         rt_e         = 5'($urandom_range(0, 3));
         write_reg_e  = 5'($urandom_range(0, 3));
         write_reg_m  = 5'($urandom_range(0, 3));
         write_reg_w  = 5'($urandom_range(0, 3));
         branch_d     = ($urandom_range(0, 3) == 0);
         pc_src_d     = 1'($urandom);
         reg_write_e  = 1'($urandom);
         mem_to_reg_e = ($urandom_range(0, 3) == 0);
         reg_write_m  = 1'($urandom);
         mem_to_reg_m = 1'($urandom);
         mem_req_m    = ($urandom_range(0, 4) == 0);
         reg_write_w  = 1'($urandom);
         settle(); tick();
      end

      // counter saturation under a held stall
      rst_n = 1'b1;
      clr();
      mem_to_reg_e = 1; write_reg_e = 7; rt_d = 7;
      for (int i = 0; i < CMAX + 4; i++) begin settle(); tick(); end
      settle(); chk("sat_cnt", stall_cycles, CMAX); tick();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
